// File: rtl/fpcvt_pkg.sv
// Shared encodings and widths for the 12-bit two's-complement to 8-bit float converter.
package fpcvt_pkg;
  localparam int DIN_W = 12;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;
  localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;

  typedef enum logic [2:0] {IDLE, MAG, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/fpcvt_mag.sv
// Combinational absolute value; the most negative operand saturates to the largest positive one.
module fpcvt_mag
  import fpcvt_pkg::*;
(
  input  logic [DIN_W-1:0] din,
  output logic [DIN_W-1:0] mag,
  output logic             neg
);
  assign neg = din[DIN_W-1];

  always_comb begin
    if (din == {1'b1, {(DIN_W-1){1'b0}}}) mag = {1'b0, {(DIN_W-1){1'b1}}};
    else if (neg)                          mag = -din;
    else                                   mag = din;
  end
endmodule

// File: rtl/fpcvt_seq.sv
// Sequential int12 -> float8 (S,E[2:0],F[3:0]) converter: magnitude, iterative normalise, round.
// Optional FPCVT_STATS_EN adds conversion/saturation counters (conv_cnt, sat_cnt).
module fpcvt_seq
  import fpcvt_pkg::*;
`ifdef FPCVT_STATS_EN
  #(parameter int CNT_W = 16)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIN_W-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s,
  output logic [EXP_W-1:0] e,
  output logic [SIG_W-1:0] f,
  output logic             busy
`ifdef FPCVT_STATS_EN
  ,
  output logic [CNT_W-1:0] conv_cnt,
  output logic [CNT_W-1:0] sat_cnt
`endif
);
  state_t           state;
  logic [DIN_W-1:0] op, w, mag;
  logic             neg;
  logic [EXP_W-1:0] e_cnt;
  logic [SIG_W:0]   f_rnd;
  logic             rnd_ovf, e_ovf;

  fpcvt_mag u_mag (.din(op), .mag(mag), .neg(neg));

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Round half up on w[6]; a carry out renormalises to 1.000 and bumps the exponent.
  assign f_rnd   = {1'b0, w[10:7]} + {{SIG_W{1'b0}}, w[6]};
  assign rnd_ovf = f_rnd[SIG_W];
  assign e_ovf   = rnd_ovf && (e_cnt == EXP_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= '0;
      w         <= '0;
      e_cnt     <= '0;
      out_valid <= 1'b0;
      s         <= 1'b0;
      e         <= '0;
      f         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op    <= din;
          state <= MAG;
        end
        MAG: begin
          w     <= mag;
          s     <= neg;
          e_cnt <= EXP_MAX;
          state <= NORM;
        end
        NORM: begin
          if (w[11:10] == 2'b00 && e_cnt != '0) begin
            w     <= w << 1;
            e_cnt <= e_cnt - 3'd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (e_ovf) begin
            e <= EXP_MAX;
            f <= 4'hF;
          end else if (rnd_ovf) begin
            e <= e_cnt + 3'd1;
            f <= 4'h8;
          end else begin
            e <= e_cnt;
            f <= f_rnd[SIG_W-1:0];
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPCVT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_cnt <= '0;
      sat_cnt  <= '0;
    end else begin
      if (state == DONE && out_ready) conv_cnt <= conv_cnt + CNT_W'(1);
      // Operand 12'h800 always ends up here too, since its saturated magnitude rounds past E=7.
      if (state == ROUND && e_ovf)    sat_cnt  <= sat_cnt + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_fpcvt_seq.sv
// Directed bench for fpcvt_seq with an arithmetic reference model and a per-cycle compare process.
module tb_fpcvt_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] din = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        s;
  logic [2:0]  e;
  logic [3:0]  f;
  logic        busy;
`ifdef FPCVT_STATS_EN
  logic [15:0] conv_cnt, sat_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fpcvt_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .e(e), .f(f), .busy(busy)
`ifdef FPCVT_STATS_EN
    , .conv_cnt(conv_cnt), .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: value = F * 2^E, F rounded half-up from |din| (saturated), E as small as possible.
  function automatic logic [7:0] ref_cvt(input logic [11:0] d, output int lat, output bit sat);
    int v, m, p, ex, fr;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
    if (m > 2047) m = 2047;
    p = -1;
    for (int i = 0; i < 12; i++) if (m >= (1 << i)) p = i;
    ex  = (p > 3) ? p - 3 : 0;
    lat = 10 - ex;
    fr  = (ex == 0) ? m : (m + (1 << (ex - 1))) >> ex;
    if (fr == 16) begin fr = 8; ex++; end
    sat = (ex > 7);
    if (sat) begin ex = 7; fr = 15; end
    return {d[11], 3'(ex), 4'(fr)};
  endfunction

  logic [7:0] r_c;
  int         lat_c;
  bit         sat_c;
  always_comb begin
    lat_c = 0;
    sat_c = 1'b0;
    r_c   = ref_cvt(din, lat_c, sat_c);
  end

  // Transaction-level model: busy from accept to output handshake, result after lat cycles.
  bit         m_busy = 1'b0;
  int         m_cnt = 0, m_lat = 0;
  logic [7:0] m_exp = '0;
  bit         m_sat = 1'b0;
  int         n_conv = 0, n_sat = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_lat  <= lat_c;
        m_exp  <= r_c;
        m_sat  <= sat_c;
      end
    end else if (m_cnt >= m_lat && out_ready) begin
      m_busy <= 1'b0;
      n_conv <= n_conv + 1;
      n_sat  <= n_sat + int'(m_sat);
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sef", 32'({s, e, f}), 32'd0);
    end else begin
      chk("cyc_in_ready", 32'(in_ready), 32'(!m_busy));
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_busy && m_cnt >= m_lat));
      if (m_busy && m_cnt >= m_lat) chk("cyc_sef", 32'({s, e, f}), 32'(m_exp));
    end
  end

  task automatic conv(input logic [11:0] d, input int hold, input logic [7:0] exp_sef, input int exp_lat);
    int n;
    bit got;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #2; n++; end
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1; din = d; out_ready = (hold == 0);
    @(posedge clk); #2;
    in_valid = 1'b0; din = d ^ 12'h5A5;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin @(posedge clk); #1; n++; got = out_valid; end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("result_sef", 32'({s, e, f}), 32'(exp_sef));
    #1;
    if (hold > 0) begin
      in_valid = 1'b1; din = ~d;
      repeat (hold) @(posedge clk);
      #2;
      chk("held_in_ready", 32'(in_ready), 32'd0);
      chk("held_out_valid", 32'(out_valid), 32'd1);
      chk("held_sef", 32'({s, e, f}), 32'(exp_sef));
      in_valid = 1'b0; out_ready = 1'b1;
    end
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  initial begin
    int l;
    bit st;
    chk("model_422", 32'(ref_cvt(12'd422, l, st)), 32'({1'b0, 3'd5, 4'd13}));
    chk("model_422_lat", 32'(l), 32'd5);
    chk("model_124", 32'(ref_cvt(12'd124, l, st)), 32'({1'b0, 3'd4, 4'd8}));
    chk("model_800", 32'(ref_cvt(12'h800, l, st)), 32'({1'b1, 3'd7, 4'd15}));
    chk("model_800_sat", 32'(st), 32'd1);
    chk("model_0_lat", 32'(l == 3 ? ref_cvt(12'd0, l, st) : 8'hFF), 32'd0);
    chk("model_0_lat10", 32'(l), 32'd10);

    #22 rst = 1'b0;
    @(posedge clk); #2;

    conv(12'd422,  0, {1'b0, 3'd5, 4'd13}, 5);
    conv(12'hE5A,  0, {1'b1, 3'd5, 4'd13}, 5);
    conv(12'd124,  0, {1'b0, 3'd4, 4'd8},  7);
    conv(12'd0,    0, {1'b0, 3'd0, 4'd0},  10);
    conv(12'h800,  0, {1'b1, 3'd7, 4'd15}, 3);
    conv(12'h7FF,  0, {1'b0, 3'd7, 4'd15}, 3);
    conv(12'd100,  0, {1'b0, 3'd3, 4'd13}, 7);
    conv(12'hFFF,  0, {1'b1, 3'd0, 4'd1},  10);
    conv(12'd1500, 0, {1'b0, 3'd7, 4'd12}, 3);
    conv(12'd1,    6, {1'b0, 3'd0, 4'd1},  10);

    // Abort a conversion while it is still normalising.
    in_valid = 1'b1; din = 12'd1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;

    conv(12'd422, 0, {1'b0, 3'd5, 4'd13}, 5);
    repeat (3) @(posedge clk);
    #1;
    chk("end_idle", 32'(in_ready), 32'd1);
`ifdef FPCVT_STATS_EN
    chk("conv_cnt", 32'(conv_cnt), 32'(n_conv));
    chk("conv_cnt_lit", 32'(conv_cnt), 32'd11);
    chk("sat_cnt", 32'(sat_cnt), 32'(n_sat));
    chk("sat_cnt_lit", 32'(sat_cnt), 32'd2);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
